// File: rtl/decode_stage_pipelined_if.sv
// Bus between the IF/ID register, the write-back port and the decode stage.
// Handshake: if_valid qualifies if_instr/if_pc; the stage accepts the
// instruction on the rising edge unless stall_if=1, in which case the
// producer must hold if_valid/if_instr/if_pc unchanged into the next cycle.
// flush overrides everything and kills the instruction currently in ID.
interface decode_stage_pipelined_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   logic             if_valid;
   logic [31:0]      if_instr;
   logic [XLEN-1:0]  if_pc;
   logic             flush;
   logic             wb_reg_write;
   logic [4:0]       wb_rd_addr;
   logic [XLEN-1:0]  wb_rd_data;

   logic             stall_if;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1_addr;
   logic [4:0]       ex_rs2_addr;
   logic [4:0]       ex_rd_addr;
   logic [3:0]       ex_funct;
   logic             ex_branch;
   logic             ex_mem_read;
   logic             ex_mem_to_reg;
   logic             ex_mem_write;
   logic             ex_alu_src;
   logic             ex_reg_write;
   logic             ex_illegal;
   logic [1:0]       ex_alu_op;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output if_valid, if_instr, if_pc, flush, wb_reg_write, wb_rd_addr, wb_rd_data,
      input  stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct, ex_branch,
             ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
             ex_reg_write, ex_illegal, ex_alu_op, stall_count, flush_count
   );

   modport slave (
      input  if_valid, if_instr, if_pc, flush, wb_reg_write, wb_rd_addr, wb_rd_data,
      output stall_if, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_funct, ex_branch,
             ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
             ex_reg_write, ex_illegal, ex_alu_op, stall_count, flush_count
   );
endinterface

// File: rtl/decode_stage_pipelined.sv
// RV64I-subset decode stage: control decode, register file with write-back
// bypass, immediate generation, ID/EX register with load-use stall and
// branch flush, and saturating stall/flush event counters.
module decode_stage_pipelined #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst,
   decode_stage_pipelined_if.slave bus
);
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1_addr;
      logic [4:0]      rs2_addr;
      logic [4:0]      rd_addr;
      logic [3:0]      funct;
      logic            branch;
      logic            mem_read;
      logic            mem_to_reg;
      logic            mem_write;
      logic            alu_src;
      logic            reg_write;
      logic            illegal;
      logic [1:0]      alu_op;
   } idex_t;

   logic [31:0]      w_instr;
   logic [6:0]       w_opcode;
   logic [4:0]       w_rs1;
   logic [4:0]       w_rs2;
   logic             w_rs2_used;
   logic [XLEN-1:0]  w_rs1_data;
   logic [XLEN-1:0]  w_rs2_data;
   logic             w_hazard;
   logic             w_stall;
   idex_t            w_dec;
   idex_t            w_next;
   idex_t            r_idex;
   logic [XLEN-1:0]  r_regs [32];
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_instr  = bus.if_instr;
   assign w_opcode = w_instr[6:0];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];

   // Register read with same-cycle write-back bypass; x0 always reads zero.
   always_comb begin
      w_rs1_data = '0;
      w_rs2_data = '0;
      if (bus.wb_reg_write && bus.wb_rd_addr != 5'd0 && bus.wb_rd_addr == w_rs1)
         w_rs1_data = bus.wb_rd_data;
      else if (w_rs1 != 5'd0)
         w_rs1_data = r_regs[w_rs1];
      if (bus.wb_reg_write && bus.wb_rd_addr != 5'd0 && bus.wb_rd_addr == w_rs2)
         w_rs2_data = bus.wb_rd_data;
      else if (w_rs2 != 5'd0)
         w_rs2_data = r_regs[w_rs2];
   end

   // Opcode decode into the candidate ID/EX contents.
   always_comb begin
      w_dec          = '0;
      w_rs2_used     = 1'b0;
      w_dec.valid    = 1'b1;
      w_dec.pc       = bus.if_pc;
      w_dec.rs1_data = w_rs1_data;
      w_dec.rs2_data = w_rs2_data;
      w_dec.rs1_addr = w_rs1;
      w_dec.rs2_addr = w_rs2;
      w_dec.rd_addr  = w_instr[11:7];
      w_dec.funct    = {w_instr[30], w_instr[14:12]};
      case (w_opcode)
         OP_R: begin
            w_dec.alu_op    = 2'b10;
            w_dec.reg_write = 1'b1;
            w_rs2_used      = 1'b1;
         end
         OP_I: begin
            w_dec.alu_op    = 2'b10;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.imm       = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
         end
         OP_LD: begin
            w_dec.alu_src    = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_dec.imm        = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
         end
         OP_ST: begin
            w_dec.alu_src   = 1'b1;
            w_dec.mem_write = 1'b1;
            w_rs2_used      = 1'b1;
            w_dec.imm       = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         end
         OP_BR: begin
            w_dec.alu_op = 2'b01;
            w_dec.branch = 1'b1;
            w_rs2_used   = 1'b1;
            w_dec.imm    = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7],
                            w_instr[30:25], w_instr[11:8], 1'b0};
         end
         default: w_dec.illegal = 1'b1;
      endcase
   end

   // Load-use hazard against the load sitting in ID/EX; flush wins over stall.
   always_comb begin
      w_hazard = bus.if_valid & r_idex.valid & r_idex.mem_read &
                 (r_idex.rd_addr != 5'd0) &
                 ((r_idex.rd_addr == w_rs1) | (w_rs2_used & (r_idex.rd_addr == w_rs2)));
      w_stall  = w_hazard & ~bus.flush;
      w_next   = (bus.flush || w_hazard || !bus.if_valid) ? idex_t'('0) : w_dec;
   end

   // Register file write port; x0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (bus.wb_reg_write && bus.wb_rd_addr != 5'd0) begin
         r_regs[bus.wb_rd_addr] <= bus.wb_rd_data;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_idex <= '0;
      else     r_idex <= w_next;
   end

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != CNT_MAX)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (bus.flush && bus.if_valid && r_flush_cnt != CNT_MAX)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.stall_if      = w_stall;
   assign bus.ex_valid      = r_idex.valid;
   assign bus.ex_pc         = r_idex.pc;
   assign bus.ex_rs1_data   = r_idex.rs1_data;
   assign bus.ex_rs2_data   = r_idex.rs2_data;
   assign bus.ex_imm        = r_idex.imm;
   assign bus.ex_rs1_addr   = r_idex.rs1_addr;
   assign bus.ex_rs2_addr   = r_idex.rs2_addr;
   assign bus.ex_rd_addr    = r_idex.rd_addr;
   assign bus.ex_funct      = r_idex.funct;
   assign bus.ex_branch     = r_idex.branch;
   assign bus.ex_mem_read   = r_idex.mem_read;
   assign bus.ex_mem_to_reg = r_idex.mem_to_reg;
   assign bus.ex_mem_write  = r_idex.mem_write;
   assign bus.ex_alu_src    = r_idex.alu_src;
   assign bus.ex_reg_write  = r_idex.reg_write;
   assign bus.ex_illegal    = r_idex.illegal;
   assign bus.ex_alu_op     = r_idex.alu_op;
   assign bus.stall_count   = r_stall_cnt;
   assign bus.flush_count   = r_flush_cnt;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: instruction-level reference model,
// per-cycle comparison, and directed vectors with literal expectations.
module tb_decode_stage_pipelined;
   localparam int XLEN  = 64;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic [63:0] pc = 64'h1000;

   decode_stage_pipelined_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   decode_stage_pipelined #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // clock / reset
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic valid; logic [63:0] pc, d1, d2, imm;
      logic [4:0] a1, a2, rd; logic [3:0] funct;
      logic branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal;
      logic [1:0] alu_op;
   } ex_t;

   typedef enum { K_R, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_BAD } kind_t;

   ex_t         m_ex;
   logic [63:0] m_regs [32];
   int          m_scnt, m_fcnt;

   function automatic ex_t bubble();
      ex_t b;
      b = '{default: '0};
      return b;
   endfunction

   function automatic kind_t kind_of(input logic [31:0] ins);
      case (ins[6:0])
         7'h33:   return K_R;
         7'h13:   return K_IALU;
         7'h03:   return K_LOAD;
         7'h23:   return K_STORE;
         7'h63:   return K_BRANCH;
         default: return K_BAD;
      endcase
   endfunction

   function automatic logic [63:0] m_read(input logic [4:0] a);
      if (bus.wb_reg_write && bus.wb_rd_addr != 0 && bus.wb_rd_addr == a) return bus.wb_rd_data;
      return m_regs[a];
   endfunction

   function automatic ex_t predict();
      ex_t e;
      logic [31:0] ins;
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      kind_t k;
      ins = bus.if_instr;
      k   = kind_of(ins);
      e = bubble();
      e.valid = 1'b1;
      e.pc = bus.if_pc;
      e.a1 = ins[19:15]; e.a2 = ins[24:20]; e.rd = ins[11:7];
      e.d1 = m_read(e.a1); e.d2 = m_read(e.a2);
      e.funct = {ins[30], ins[14:12]};
      case (k)
         K_R:      begin e.alu_op = 2; e.reg_write = 1; end
         K_IALU:   begin e.alu_op = 2; e.alu_src = 1; e.reg_write = 1;
                         i12 = ins[31:20]; e.imm = 64'(i12); end
         K_LOAD:   begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1;
                         i12 = ins[31:20]; e.imm = 64'(i12); end
         K_STORE:  begin e.alu_src = 1; e.mem_write = 1;
                         i12 = {ins[31:25], ins[11:7]}; e.imm = 64'(i12); end
         K_BRANCH: begin e.alu_op = 1; e.branch = 1;
                         b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; e.imm = 64'(b13); end
         default:  e.illegal = 1;
      endcase
      return e;
   endfunction

   function automatic logic m_hazard();
      kind_t k;
      logic  uses2;
      k = kind_of(bus.if_instr);
      uses2 = (k == K_R) || (k == K_STORE) || (k == K_BRANCH);
      return bus.if_valid && m_ex.valid && m_ex.mem_read && m_ex.rd != 0 &&
             (m_ex.rd == bus.if_instr[19:15] || (uses2 && m_ex.rd == bus.if_instr[24:20]));
   endfunction

   always @(posedge clk or posedge rst) begin
      logic hz;
      if (rst) begin
         m_ex = bubble();
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_scnt = 0; m_fcnt = 0;
      end else begin
         hz = m_hazard();
         if (hz && !bus.flush && m_scnt < CMAX) m_scnt++;
         if (bus.flush && bus.if_valid && m_fcnt < CMAX) m_fcnt++;
         m_ex = (bus.flush || hz || !bus.if_valid) ? bubble() : predict();
         if (bus.wb_reg_write && bus.wb_rd_addr != 0) m_regs[bus.wb_rd_addr] = bus.wb_rd_data;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      chk("cyc_stall_if", bus.stall_if, m_hazard() && !bus.flush);
      chk("cyc_valid", bus.ex_valid, m_ex.valid);
      chk("cyc_pc", bus.ex_pc, m_ex.pc);
      chk("cyc_rs1_data", bus.ex_rs1_data, m_ex.d1);
      chk("cyc_rs2_data", bus.ex_rs2_data, m_ex.d2);
      chk("cyc_imm", bus.ex_imm, m_ex.imm);
      chk("cyc_addrs", {bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr}, {m_ex.a1, m_ex.a2, m_ex.rd});
      chk("cyc_funct", bus.ex_funct, m_ex.funct);
      chk("cyc_ctrl", {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                       bus.ex_alu_src, bus.ex_reg_write, bus.ex_illegal, bus.ex_alu_op},
                      {m_ex.branch, m_ex.mem_read, m_ex.mem_to_reg, m_ex.mem_write,
                       m_ex.alu_src, m_ex.reg_write, m_ex.illegal, m_ex.alu_op});
      chk("cyc_stall_count", bus.stall_count, m_scnt);
      chk("cyc_flush_count", bus.flush_count, m_fcnt);
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [11:0] imm);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_sd(input logic [4:0] rs1, rs2, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_beq(input logic [4:0] rs1, rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic set(input logic v, input logic [31:0] ins, input logic fl,
                      input logic wbw, input logic [4:0] wba, input logic [63:0] wbd);
      bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc; bus.flush = fl;
      bus.wb_reg_write = wbw; bus.wb_rd_addr = wba; bus.wb_rd_data = wbd;
   endtask
   task automatic set_i(input logic [31:0] ins);
      set(1'b1, ins, 1'b0, 1'b0, 5'd0, 64'd0);
   endtask
   task automatic tick();
      @(posedge clk); #1;
      pc = pc + 64'd4;
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      logic [31:0] ld7, use7, noun;
      ld7  = enc_i(7'b0000011, 5'd7, 3'b011, 5'd1, 12'd0);
      use7 = enc_add(5'd8, 5'd7, 5'd2);
      noun = enc_i(7'b0010011, 5'd8, 3'b000, 5'd9, 12'd4);

      rst = 1'b1;
      set(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.ex_valid, 0);
      chk("rst_counts", {bus.stall_count, bus.flush_count}, 0);
      rst = 1'b0;

      // bypass x5 and x0
      set(1'b1, enc_add(5'd6, 5'd5, 5'd5), 1'b0, 1'b1, 5'd5, 64'h1234);
      tick();
      chk("byp_rs1", bus.ex_rs1_data, 64'h1234);
      chk("byp_rs2", bus.ex_rs2_data, 64'h1234);
      chk("byp_valid", bus.ex_valid, 1);
      set(1'b1, enc_add(5'd6, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 64'h5555);
      tick();
      chk("byp_x0", {bus.ex_rs1_data, bus.ex_rs2_data}, 0);

      // immediates
      set_i(32'hFFF00093);                       // addi x1,x0,-1
      tick();
      chk("addi_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_ctl", {bus.ex_alu_src, bus.ex_alu_op, bus.ex_reg_write}, 4'b1101);
      set_i(enc_sd(5'd2, 5'd3, 12'hFF8));          // sd x3,-8(x2)
      tick();
      chk("sd_imm", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("sd_mw", {bus.ex_mem_write, bus.ex_reg_write}, 2'b10);
      set_i(enc_beq(5'd1, 5'd2, 13'd16));          // beq x1,x2,+16
      tick();
      chk("beq_imm", bus.ex_imm, 64'd16);
      chk("beq_ctl", {bus.ex_branch, bus.ex_alu_op}, 3'b101);

      // load-use stall
      set_i(ld7); tick();
      set_i(use7); #1;
      chk("lu_stall", bus.stall_if, 1);
      tick();
      chk("lu_bubble", bus.ex_valid, 0);
      chk("lu_unstall", bus.stall_if, 0);
      tick();
      chk("lu_enter", {bus.ex_valid, bus.ex_rd_addr}, {1'b1, 5'd8});
      chk("lu_count", bus.stall_count, 1);

      // independent instruction after load
      set_i(ld7); tick();
      set_i(noun); #1;
      chk("nolu_stall", bus.stall_if, 0);
      tick();
      chk("nolu_valid", bus.ex_valid, 1);
      chk("nolu_count", bus.stall_count, 1);

      // asynchronous reset in the middle of a stall
      set_i(ld7); tick();
      set_i(use7); #1;
      chk("mid_stall", bus.stall_if, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", bus.ex_valid, 0);
      chk("arst_outs", {bus.ex_pc, bus.ex_imm, bus.ex_rd_addr, bus.ex_mem_read}, 0);
      chk("arst_stall", bus.stall_if, 0);
      chk("arst_counts", {bus.stall_count, bus.flush_count}, 0);
      @(negedge clk); #1 rst = 1'b0;
      set_i(enc_add(5'd6, 5'd5, 5'd5));
      tick();
      chk("arst_regs", {bus.ex_rs1_data, bus.ex_rs2_data}, 0);

      // flush coincident with load-use hazard
      set_i(ld7); tick();
      set(1'b1, use7, 1'b1, 1'b0, 5'd0, 64'd0); #1;
      chk("fl_stall", bus.stall_if, 0);
      tick();
      chk("fl_bubble", bus.ex_valid, 0);
      chk("fl_fcount", bus.flush_count, 1);
      chk("fl_scount", bus.stall_count, 0);

      // five stalls saturate a 2-bit counter at 3
      for (int n = 0; n < 5; n++) begin
         set_i(ld7); tick();
         set_i(use7); tick(); tick();
         if (n == 2) chk("sat_three", bus.stall_count, 3);
      end
      chk("sat_five", bus.stall_count, 3);

      // illegal opcode
      set_i(32'h0000007F); tick();
      chk("ill_valid", {bus.ex_valid, bus.ex_illegal}, 2'b11);
      chk("ill_ctl", {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
                      bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op}, 0);
      chk("ill_imm", bus.ex_imm, 0);

      // no valid instruction
      set(1'b0, use7, 1'b0, 1'b0, 5'd0, 64'd0); tick();
      chk("idle_bubble", bus.ex_valid, 0);
      chk("idle_fcount", bus.flush_count, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
